// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg: shared defaults and next-address select encoding for the program counter
package prog_counter_pkg;
  localparam int PC_WIDTH_DEF = 5;
  localparam int PC_STEP_DEF = 4;
  typedef enum logic [1:0] {PC_SEL_HOLD, PC_SEL_SEQ, PC_SEL_BRANCH, PC_SEL_JUMP} pc_sel_t;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: decodes load/jump/branch into a select and forms the next PC (carry-out when PC_WRAP_DETECT_EN is defined)
module pc_next_mux
  import prog_counter_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input logic [PC_WIDTH-1:0] i_pc,
  input logic i_ld,
  input logic i_jmp,
  input logic i_pc_src,
  input logic [PC_WIDTH-1:0] i_off,
  output pc_sel_t o_sel,
`ifdef PC_WRAP_DETECT_EN
  output logic o_carry,
`endif
  output logic [PC_WIDTH-1:0] o_next
);
`ifdef PC_WRAP_DETECT_EN
  // two spare bits hold the carry of pc + step + offset, which can exceed one extra bit
  localparam int XW = PC_WIDTH + 2;
`else
  localparam int XW = PC_WIDTH;
`endif
  logic [XW-1:0] w_seq;
  logic [XW-1:0] w_br;
  // jump beats branch, and nothing moves without load
  always_comb begin
    w_seq = XW'(i_pc) + XW'(PC_STEP);
    w_br = w_seq + XW'(i_off);
    o_sel = !i_ld ? PC_SEL_HOLD : i_jmp ? PC_SEL_JUMP : i_pc_src ? PC_SEL_BRANCH : PC_SEL_SEQ;
    o_next = (o_sel == PC_SEL_JUMP) ? i_off : (o_sel == PC_SEL_BRANCH) ? w_br[PC_WIDTH-1:0] : w_seq[PC_WIDTH-1:0];
`ifdef PC_WRAP_DETECT_EN
    o_carry = (o_sel == PC_SEL_SEQ) ? |w_seq[XW-1:PC_WIDTH] : (o_sel == PC_SEL_BRANCH) ? |w_br[XW-1:PC_WIDTH] : 1'b0;
`endif
  end
endmodule

// File: rtl/prog_counter.sv
// prog_counter: MIPS program counter register with async reset; PC_WRAP_DETECT_EN adds the registered pcWrap flag
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF,
  parameter int PC_STEP = PC_STEP_DEF
) (
  input logic clk,
  input logic counterRst,
  input logic counterLd,
  input logic pcSrc,
  input logic jmp,
  input logic [PC_WIDTH-1:0] shiftLeft2Out,
`ifdef PC_WRAP_DETECT_EN
  output logic pcWrap,
`endif
  output logic [PC_WIDTH-1:0] nextCount
);
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_next;
  pc_sel_t w_sel;
`ifdef PC_WRAP_DETECT_EN
  logic w_carry;
  logic r_wrap;
`endif
  pc_next_mux #(.PC_WIDTH(PC_WIDTH), .PC_STEP(PC_STEP)) u_mux (
    .i_pc(r_pc),
    .i_ld(counterLd),
    .i_jmp(jmp),
    .i_pc_src(pcSrc),
    .i_off(shiftLeft2Out),
    .o_sel(w_sel),
`ifdef PC_WRAP_DETECT_EN
    .o_carry(w_carry),
`endif
    .o_next(w_next)
  );
  // PC register: cleared asynchronously, updated only on a load edge
  always_ff @(posedge clk or posedge counterRst)
    if (counterRst) r_pc <= '0;
    else if (w_sel != PC_SEL_HOLD) r_pc <= w_next;
  assign nextCount = r_pc;
`ifdef PC_WRAP_DETECT_EN
  // wrap flag follows the carry of each load and holds while loading is off
  always_ff @(posedge clk or posedge counterRst)
    if (counterRst) r_wrap <= 1'b0;
    else if (w_sel != PC_SEL_HOLD) r_wrap <= w_carry;
  assign pcWrap = r_wrap;
`endif
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed self-checking bench for prog_counter
module tb_prog_counter;
  logic clk = 1'b0;
  logic counterRst, counterLd, pcSrc, jmp;
  logic [4:0] shiftLeft2Out;
  logic [4:0] nextCount;
  int checks = 0;
  int errors = 0;
  int exp_pc;
`ifdef PC_WRAP_DETECT_EN
  logic pcWrap;
`endif
  prog_counter dut (
    .clk(clk),
    .counterRst(counterRst),
    .counterLd(counterLd),
    .pcSrc(pcSrc),
    .jmp(jmp),
    .shiftLeft2Out(shiftLeft2Out),
`ifdef PC_WRAP_DETECT_EN
    .pcWrap(pcWrap),
`endif
    .nextCount(nextCount)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk_wrap(input string tag, input logic exp);
`ifdef PC_WRAP_DETECT_EN
    chk(tag, 32'(pcWrap), 32'(exp));
`endif
  endtask
  initial begin
    counterRst = 1'b1;
    counterLd = 1'b1;
    pcSrc = 1'b0;
    jmp = 1'b0;
    shiftLeft2Out = 5'd0;
    #1;
    chk("reset_async", 32'(nextCount), 0);
    chk_wrap("reset_wrap", 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", 32'(nextCount), 0);
    end
    counterRst = 1'b0;
    tick();
    chk("first_step", 32'(nextCount), 4);
    exp_pc = 4;
    for (int i = 0; i < 7; i++) begin
      tick();
      exp_pc = (exp_pc + 4) % 32;
      chk("seq", 32'(nextCount), 32'(exp_pc));
    end
    chk("seq_wrap_zero", 32'(nextCount), 0);
    chk_wrap("seq_wrap_flag", 1'b1);
    tick();
    chk("seq_after_wrap", 32'(nextCount), 4);
    chk_wrap("seq_wrap_clear", 1'b0);
    tick();
    chk("seq_to_8", 32'(nextCount), 8);
    counterLd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold", 32'(nextCount), 8);
    end
    counterLd = 1'b1;
    tick();
    chk("resume_12", 32'(nextCount), 12);
    #1 counterRst = 1'b1;
    #1 chk("async_mid", 32'(nextCount), 0);
    #1 counterRst = 1'b0;
    tick();
    chk("resume_4", 32'(nextCount), 4);
    tick();
    chk("resume_8", 32'(nextCount), 8);
    jmp = 1'b1;
    #2 jmp = 1'b0;
    tick();
    chk("narrow_pulse", 32'(nextCount), 12);
    #1 counterRst = 1'b1;
    #1 chk("rst_before_branch", 32'(nextCount), 0);
    counterRst = 1'b0;
    pcSrc = 1'b1;
    shiftLeft2Out = 5'd2;
    tick();
    chk("branch_6", 32'(nextCount), 6);
    tick();
    chk("branch_12", 32'(nextCount), 12);
    tick();
    chk("branch_18", 32'(nextCount), 18);
    pcSrc = 1'b0;
    jmp = 1'b1;
    shiftLeft2Out = 5'd20;
    tick();
    chk("jump_20", 32'(nextCount), 20);
    pcSrc = 1'b1;
    shiftLeft2Out = 5'd0;
    tick();
    chk("jump_priority", 32'(nextCount), 0);
    chk_wrap("jump_no_wrap", 1'b0);
    jmp = 1'b0;
    pcSrc = 1'b0;
    tick();
    chk("after_jump", 32'(nextCount), 4);
    pcSrc = 1'b1;
    shiftLeft2Out = 5'd28;
    tick();
    chk("branch_wrap", 32'(nextCount), 4);
    chk_wrap("branch_wrap_flag", 1'b1);
    counterLd = 1'b0;
    tick();
    chk("hold_wrap_pc", 32'(nextCount), 4);
    chk_wrap("hold_wrap_flag", 1'b1);
    counterLd = 1'b1;
    pcSrc = 1'b0;
    jmp = 1'b1;
    shiftLeft2Out = 5'd31;
    tick();
    chk("jump_31", 32'(nextCount), 31);
    chk_wrap("jump_clears_wrap", 1'b0);
    jmp = 1'b0;
    tick();
    chk("wrap_31_to_3", 32'(nextCount), 3);
    chk_wrap("wrap_31_flag", 1'b1);
    counterRst = 1'b1;
    counterLd = 1'b1;
    jmp = 1'b1;
    tick();
    chk("rst_beats_load", 32'(nextCount), 0);
    chk_wrap("rst_clears_wrap", 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
